// File: rtl/ifu_fetch_unit_if.sv
// rtl/ifu_fetch_unit_if.sv - instruction-memory and decoder handshakes of the fetch unit
interface ifu_fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output inst_valid, inst_out, inst_pc,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  inst_valid, inst_out, inst_pc,
      output inst_ready
   );
endinterface

// File: rtl/ifu_fetch_unit.sv
// rtl/ifu_fetch_unit.sv - fetch stage: PC, single-outstanding imem reads, {pc,instr} FIFO
// Optional feature macro: ALIGN_CHECK_EN (misaligned redirect flag and fetch block).
module ifu_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      npc,
   input  logic             npc_load,
   ifu_fetch_unit_if.master bus
`ifdef ALIGN_CHECK_EN
   ,
   output logic             fetch_misalign
`endif
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   state_t        state, state_nxt;
   logic [31:0]   pc, req_addr;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [31:0]   fifo_pc    [FIFO_DEPTH];
   logic [31:0]   fifo_instr [FIFO_DEPTH];
   logic          hs, pop, push, blocked;
   logic [31:0]   npc_aligned;

   assign npc_aligned = npc & 32'hFFFF_FFFC;

`ifdef ALIGN_CHECK_EN
   logic misalign_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else if (npc_load) begin
         misalign_q <= |npc[1:0];
      end
   end

   assign blocked        = misalign_q;
   assign fetch_misalign = misalign_q;
`else
   assign blocked = 1'b0;
`endif

   // Outputs are forced low while reset is asserted, not just after the first edge.
   assign bus.imem_req_valid = rst_n && (state == S_REQ) && (count < DEPTH_C) && !blocked;
   assign bus.imem_req_addr  = rst_n ? pc : 32'h0;
   assign bus.inst_valid     = (count != '0);
   assign bus.inst_out       = bus.inst_valid ? fifo_instr[rd_ptr] : 32'h0;
   assign bus.inst_pc        = bus.inst_valid ? fifo_pc[rd_ptr]    : 32'h0;

   assign hs  = bus.imem_req_valid && bus.imem_req_ready;
   assign pop = bus.inst_valid && bus.inst_ready;

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         S_REQ: begin
            if (npc_load) begin
               state_nxt = hs ? S_DROP : S_REQ;
            end else if (hs) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.imem_rsp_valid) begin
               state_nxt = S_REQ;
               push      = !npc_load;
            end else if (npc_load) begin
               state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (bus.imem_rsp_valid) begin
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         req_addr <= 32'h0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (npc_load) begin
            pc <= npc_aligned;
         end else if (hs) begin
            pc <= pc + 32'd4;
         end
         if (hs) begin
            req_addr <= pc;
         end
         // A redirect flushes everything, including a same-cycle pop or push.
         if (npc_load) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= req_addr;
         fifo_instr[wr_ptr] <= bus.imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_ifu_fetch_unit.sv
// tb/tb_ifu_fetch_unit.sv - self-checking bench for ifu_fetch_unit with memory and stream model
module tb_ifu_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] npc = 32'h0;
   logic        npc_load = 1'b0;

   ifu_fetch_unit_if bus();

`ifdef ALIGN_CHECK_EN
   logic fetch_misalign;
`endif

   ifu_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .npc      (npc),
      .npc_load (npc_load),
      .bus      (bus)
`ifdef ALIGN_CHECK_EN
      ,
      .fetch_misalign (fetch_misalign)
`endif
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_pop = 0;
   bit          in_reset;
   bit          pending, stale, mis;
   logic [31:0] paddr;
   int          pdelay, lat_min, lat_max, occ, p0;
   logic [31:0] req_pc, exp_pc;
   logic [31:0] hs_log[$];

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      occ    = 0;
      req_pc = RST_PC;
      exp_pc = RST_PC;
      mis    = 1'b0;
      hs_log.delete();
   endtask

   // One clock: sample and check just before the edge, advance the model just after it.
   task automatic tick();
      bit          hs, pop, rsp, ld;
      logic [31:0] a, ld_npc;
      #1;
      hs     = bus.imem_req_valid && bus.imem_req_ready;
      pop    = bus.inst_valid && bus.inst_ready;
      rsp    = bus.imem_rsp_valid;
      ld     = npc_load;
      ld_npc = npc;
      a      = bus.imem_req_addr;
      if (!in_reset) begin
         chk("inst_valid", bus.inst_valid, occ != 0);
         chk("req_valid", bus.imem_req_valid, !pending && occ < DEPTH && !mis);
`ifdef ALIGN_CHECK_EN
         chk("misalign", fetch_misalign, mis);
`endif
         if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, req_pc);
         if (pop) begin
            chk("pop_pc", bus.inst_pc, exp_pc);
            chk("pop_instr", bus.inst_out, mem_fn(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pop++;
         end
      end
      @(posedge clk);
      #1;
      if (in_reset) begin
         model_reset();
      end else if (ld) begin
         occ    = 0;
         req_pc = ld_npc & 32'hFFFF_FFFC;
         exp_pc = req_pc;
`ifdef ALIGN_CHECK_EN
         mis = (ld_npc[1:0] != 2'b00);
`endif
      end else begin
         occ = occ + ((rsp && !stale) ? 1 : 0) - (pop ? 1 : 0);
         if (hs) req_pc = req_pc + 32'd4;
      end
      if (rsp) begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
         pending = 1'b0;
         stale   = 1'b0;
      end
      if (ld && pending) stale = 1'b1;
      if (hs) begin
         pending = 1'b1;
         stale   = ld;
         paddr   = a;
         pdelay  = $urandom_range(lat_max, lat_min);
         hs_log.push_back(a);
      end
      if (pending && !bus.imem_rsp_valid) begin
         if (pdelay == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_fn(paddr);
         end else begin
            pdelay--;
         end
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_reset = 1'b1;
      model_reset();
      repeat (2) tick();
      pending = 1'b0;
      stale   = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      rst_n    = 1'b1;
      in_reset = 1'b0;
   endtask

   task automatic load(input logic [31:0] v);
      npc      = v;
      npc_load = 1'b1;
      tick();
      npc_load = 1'b0;
   endtask

   initial begin
      bus.imem_req_ready = 1'b1;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
      bus.inst_ready     = 1'b0;
      lat_min = 0;
      lat_max = 0;
      pending = 1'b0;
      stale   = 1'b0;
      in_reset = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_req_addr", bus.imem_req_addr, 0);
      chk("rst_inst_valid", bus.inst_valid, 0);
      chk("rst_inst_out", bus.inst_out, 0);
      chk("rst_inst_pc", bus.inst_pc, 0);
      rst_n    = 1'b1;
      in_reset = 1'b0;

      // Sequential fetch with a 1-cycle memory.
      bus.inst_ready = 1'b1;
      for (int k = 0; k < 40 && (hs_log.size() < 3 || n_pop < 3); k++) tick();
      chk("t1_done", hs_log.size() >= 3 && n_pop >= 3, 1);
      chk("t1_addr0", hs_log[0], 32'h3000);
      chk("t1_addr1", hs_log[1], 32'h3004);
      chk("t1_addr2", hs_log[2], 32'h3008);

      // Decoder stalled: exactly DEPTH requests, then drain in order.
      do_reset();
      bus.inst_ready = 1'b0;
      lat_max = 2;
      repeat (14) tick();
      chk("hold_reqs", hs_log.size(), DEPTH);
      chk("hold_req_valid", bus.imem_req_valid, 0);
      p0 = n_pop;
      bus.inst_ready = 1'b1;
      repeat (20) tick();
      chk("drain_pops", n_pop - p0 > DEPTH, 1);

      // Redirect while waiting on the 0x3008 response.
      do_reset();
      lat_min = 2;
      lat_max = 2;
      for (int k = 0; k < 40 && !(hs_log.size() > 0 && hs_log[hs_log.size()-1] == 32'h3008); k++) tick();
      chk("t3_reach_wait", hs_log.size() > 0 && hs_log[hs_log.size()-1] == 32'h3008, 1);
      load(32'h3100);
      hs_log.delete();
      for (int k = 0; k < 20 && hs_log.size() == 0; k++) tick();
      chk("t3_redir_addr", hs_log.size() > 0 ? hs_log[0] : 32'hFFFF_FFFF, 32'h3100);
      repeat (20) tick();

      // Redirect in the same cycle as a response and a pop.
      do_reset();
      lat_min = 0;
      lat_max = 0;
      bus.inst_ready = 1'b0;
      for (int k = 0; k < 20 && !(bus.imem_rsp_valid && bus.inst_valid); k++) tick();
      chk("t4_setup", bus.imem_rsp_valid && bus.inst_valid, 1);
      p0 = n_pop;
      bus.inst_ready = 1'b1;
      load(32'h3200);
      bus.inst_ready = 1'b0;
      chk("t4_pop_once", n_pop - p0, 1);
      chk("t4_empty", bus.inst_valid, 0);
      bus.inst_ready = 1'b1;
      repeat (10) tick();

      // PC wraps from the top of the address space.
      load(32'hFFFF_FFFC);
      hs_log.delete();
      for (int k = 0; k < 20 && hs_log.size() < 2; k++) tick();
      chk("wrap_first", hs_log.size() > 0 ? hs_log[0] : 32'h1, 32'hFFFF_FFFC);
      chk("wrap_next", hs_log.size() > 1 ? hs_log[1] : 32'h1, 32'h0);
      repeat (6) tick();

      // Asynchronous reset while a response is outstanding.
      lat_min = 2;
      lat_max = 2;
      hs_log.delete();
      for (int k = 0; k < 20 && hs_log.size() == 0; k++) tick();
      chk("t6_in_wait", pending, 1);
      rst_n = 1'b0;
      #1;
      chk("async_req_valid", bus.imem_req_valid, 0);
      chk("async_req_addr", bus.imem_req_addr, 0);
      chk("async_inst_valid", bus.inst_valid, 0);
      chk("async_inst_out", bus.inst_out, 0);
      chk("async_inst_pc", bus.inst_pc, 0);
      in_reset = 1'b1;
      model_reset();
      repeat (4) tick();
      pending = 1'b0;
      stale   = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      rst_n    = 1'b1;
      in_reset = 1'b0;
      lat_min = 0;
      lat_max = 0;
      for (int k = 0; k < 20 && hs_log.size() == 0; k++) tick();
      chk("t6_refetch", hs_log.size() > 0 ? hs_log[0] : 32'h1, 32'h3000);
      repeat (8) tick();

`ifdef ALIGN_CHECK_EN
      load(32'h3102);
      chk("mis_set", fetch_misalign, 1);
      hs_log.delete();
      repeat (10) tick();
      chk("mis_noreq", hs_log.size(), 0);
      load(32'h3200);
      chk("mis_clr", fetch_misalign, 0);
      for (int k = 0; k < 20 && hs_log.size() == 0; k++) tick();
      chk("mis_resume", hs_log.size() > 0 ? hs_log[0] : 32'h1, 32'h3200);
`else
      load(32'h3102);
      hs_log.delete();
      for (int k = 0; k < 20 && hs_log.size() == 0; k++) tick();
      chk("force_align", hs_log.size() > 0 ? hs_log[0] : 32'h1, 32'h3100);
`endif
      repeat (6) tick();

      // Randomized traffic: stalls, memory latency, ready gaps and redirects.
      lat_min = 0;
      lat_max = 3;
      for (int k = 0; k < 500; k++) begin
         bus.inst_ready     = ($urandom % 4) != 0;
         bus.imem_req_ready = ($urandom % 3) != 0;
         if (($urandom % 20) == 0) begin
            npc = (($urandom % 4) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            npc_load = 1'b1;
         end
         tick();
         npc_load = 1'b0;
      end
      bus.inst_ready     = 1'b1;
      bus.imem_req_ready = 1'b1;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
